// File: rtl/cr_su_hb_capture.sv
// rtl/cr_su_hb_capture.sv - 8-entry SU status history buffer with trigger/post-trigger freeze
// Captured words are exposed in parallel; a strobe per accepted word feeds the aggregate counter.
module cr_su_hb_capture #(
   parameter int N_ENTRIES = 8,
   parameter int DATA_W    = 108,
   parameter int CNT_W     = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_vld,
   input  logic [DATA_W-1:0]                    in_data,
   input  logic                                 trig,
   input  logic                                 hb_clear,
   input  logic                                 hb_freeze,
   input  logic [CNT_W-1:0]                     cfg_post_trig,
   output logic [N_ENTRIES-1:0][DATA_W-1:0]     su_hb,
   output logic [$clog2(N_ENTRIES)-1:0]         hb_wr_ptr,
   output logic [$clog2(N_ENTRIES)-1:0]         hb_trig_ptr,
   output logic                                 hb_wrapped,
   output logic [1:0]                           hb_state,
   output logic                                 su_agg_cnt_stb
);

   localparam int PTR_W = $clog2(N_ENTRIES);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(N_ENTRIES - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_POST   = 2'd1,
      ST_FROZEN = 2'd2
   } state_e;

   state_e                          state_q, state_d;
   logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                trig_ptr_q, trig_ptr_d;
   logic                            wrapped_q, wrapped_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            stb_q, stb_d;
   logic [N_ENTRIES-1:0][DATA_W-1:0] hb_q;
   logic                            acc;

   always_comb begin
      acc        = in_vld & ~hb_freeze & (state_q != ST_FROZEN) & ~hb_clear;
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      trig_ptr_d = trig_ptr_q;
      cnt_d      = cnt_q;
      stb_d      = acc;
      wrapped_d  = wrapped_q | (acc & (wr_ptr_q == PTR_MAX));
      if (acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (hb_clear) begin
         // Re-arm drops any same-cycle word and trigger; entries are kept.
         state_d    = ST_RUN;
         wr_ptr_d   = '0;
         trig_ptr_d = '0;
         wrapped_d  = 1'b0;
         cnt_d      = '0;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (trig && !hb_freeze) begin
                  trig_ptr_d = wr_ptr_d;
                  if (cfg_post_trig == '0) begin
                     state_d = ST_FROZEN;
                  end else begin
                     state_d = ST_POST;
                     cnt_d   = cfg_post_trig;
                  end
               end
            end
            ST_POST: begin
               if (acc && cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = ST_FROZEN;
                  end
               end
            end
            ST_FROZEN: begin
               state_d = ST_FROZEN;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         wr_ptr_q   <= '0;
         trig_ptr_q <= '0;
         wrapped_q  <= 1'b0;
         cnt_q      <= '0;
         stb_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         trig_ptr_q <= trig_ptr_d;
         wrapped_q  <= wrapped_d;
         cnt_q      <= cnt_d;
         stb_q      <= stb_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_q <= '0;
      end else if (acc) begin
         hb_q[wr_ptr_q] <= in_data;
      end
   end

   assign su_hb          = hb_q;
   assign hb_wr_ptr      = wr_ptr_q;
   assign hb_trig_ptr    = trig_ptr_q;
   assign hb_wrapped     = wrapped_q;
   assign hb_state       = state_q;
   assign su_agg_cnt_stb = stb_q;

endmodule

// File: tb/tb_cr_su_hb_capture.sv
// tb/tb_cr_su_hb_capture.sv - directed self-checking bench for cr_su_hb_capture
module tb_cr_su_hb_capture;

   localparam int N  = 8;
   localparam int DW = 108;
   localparam int CW = 8;

   logic                   clk;
   logic                   rst_n;
   logic                   in_vld;
   logic [DW-1:0]          in_data;
   logic                   trig;
   logic                   hb_clear;
   logic                   hb_freeze;
   logic [CW-1:0]          cfg_post_trig;
   logic [N-1:0][DW-1:0]   su_hb;
   logic [2:0]             hb_wr_ptr;
   logic [2:0]             hb_trig_ptr;
   logic                   hb_wrapped;
   logic [1:0]             hb_state;
   logic                   su_agg_cnt_stb;

   int checks   = 0;
   int failures = 0;
   int stb_cnt  = 0;
   logic [DW-1:0] exp_hb [N];

   cr_su_hb_capture #(.N_ENTRIES(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_vld         (in_vld),
      .in_data        (in_data),
      .trig           (trig),
      .hb_clear       (hb_clear),
      .hb_freeze      (hb_freeze),
      .cfg_post_trig  (cfg_post_trig),
      .su_hb          (su_hb),
      .hb_wr_ptr      (hb_wr_ptr),
      .hb_trig_ptr    (hb_trig_ptr),
      .hb_wrapped     (hb_wrapped),
      .hb_state       (hb_state),
      .su_agg_cnt_stb (su_agg_cnt_stb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Applies one cycle of inputs, samples 1 ns after the edge, then idles the pulses.
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic t,
                        input logic c, input logic f);
      in_vld    = v;
      in_data   = d;
      trig      = t;
      hb_clear  = c;
      hb_freeze = f;
      @(posedge clk);
      #1;
      in_vld    = 1'b0;
      trig      = 1'b0;
      hb_clear  = 1'b0;
      hb_freeze = 1'b0;
      if (su_agg_cnt_stb) stb_cnt++;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      in_vld = 1'b0; in_data = '0; trig = 1'b0; hb_clear = 1'b0;
      hb_freeze = 1'b0; cfg_post_trig = '0;
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (su_hb !== '0) begin failures++; $display("FAIL reset_su_hb got=%0h exp=0", su_hb); end
      checks++;
      if ({hb_wr_ptr, hb_trig_ptr, hb_wrapped, hb_state, su_agg_cnt_stb} !== '0) begin
         failures++;
         $display("FAIL reset_status got wr=%0d trig=%0d wrap=%0b st=%0d stb=%0b exp all 0",
                  hb_wr_ptr, hb_trig_ptr, hb_wrapped, hb_state, su_agg_cnt_stb);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_capture;
      stb_cnt = 0;
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
         checks++;
         if (su_agg_cnt_stb !== 1'b1) begin
            failures++; $display("FAIL cap_stb_%0d got=%0b exp=1", i, su_agg_cnt_stb);
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (su_agg_cnt_stb !== 1'b0) begin failures++; $display("FAIL cap_stb_idle got=%0b exp=0", su_agg_cnt_stb); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (su_hb[i] !== DW'(i + 1)) begin
            failures++; $display("FAIL cap_entry_%0d got=%0h exp=%0h", i, su_hb[i], i + 1);
         end
      end
      checks++;
      if (hb_wr_ptr !== 3'd5) begin failures++; $display("FAIL cap_wr_ptr got=%0d exp=5", hb_wr_ptr); end
      checks++;
      if (hb_wrapped !== 1'b0) begin failures++; $display("FAIL cap_wrapped got=%0b exp=0", hb_wrapped); end
      checks++;
      if (stb_cnt != 5) begin failures++; $display("FAIL cap_stb_count got=%0d exp=5", stb_cnt); end
   endtask

   task automatic test_wrap;
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (hb_wr_ptr !== 3'd0) begin failures++; $display("FAIL wrap_clear_ptr got=%0d exp=0", hb_wr_ptr); end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
         if (i == 6) begin
            checks++;
            if (hb_wrapped !== 1'b0) begin failures++; $display("FAIL wrap_early got=%0b exp=0", hb_wrapped); end
         end
         if (i == 7) begin
            checks++;
            if (hb_wrapped !== 1'b1) begin failures++; $display("FAIL wrap_at_7 got=%0b exp=1", hb_wrapped); end
         end
      end
      checks++;
      if (su_hb[0] !== DW'(8'hA8)) begin failures++; $display("FAIL wrap_e0 got=%0h exp=a8", su_hb[0]); end
      checks++;
      if (su_hb[1] !== DW'(8'hA9)) begin failures++; $display("FAIL wrap_e1 got=%0h exp=a9", su_hb[1]); end
      checks++;
      if (su_hb[2] !== DW'(8'hA2)) begin failures++; $display("FAIL wrap_e2 got=%0h exp=a2", su_hb[2]); end
      checks++;
      if (hb_wr_ptr !== 3'd2) begin failures++; $display("FAIL wrap_ptr got=%0d exp=2", hb_wr_ptr); end
      checks++;
      if (hb_wrapped !== 1'b1) begin failures++; $display("FAIL wrap_flag got=%0b exp=1", hb_wrapped); end
   endtask

   task automatic test_trigger;
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, DW'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
      cfg_post_trig = 8'd3;
      stb_cnt = 0;
      drive(1'b1, DW'(8'hC0), 1'b1, 1'b0, 1'b0);
      checks++;
      if (hb_trig_ptr !== 3'd5) begin failures++; $display("FAIL trig_ptr got=%0d exp=5", hb_trig_ptr); end
      checks++;
      if (hb_state !== 2'd1) begin failures++; $display("FAIL trig_post got=%0d exp=1", hb_state); end
      cfg_post_trig = 8'd9;
      for (int i = 1; i <= 6; i++) drive(1'b1, DW'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         exp_hb[i]     = DW'(8'hB0 + i);
         exp_hb[i + 4] = DW'(8'hC0 + i);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (su_hb[i] !== exp_hb[i]) begin
            failures++; $display("FAIL trig_entry_%0d got=%0h exp=%0h", i, su_hb[i], exp_hb[i]);
         end
      end
      checks++;
      if (hb_state !== 2'd2) begin failures++; $display("FAIL trig_frozen got=%0d exp=2", hb_state); end
      checks++;
      if (hb_wr_ptr !== 3'd0) begin failures++; $display("FAIL trig_wr_ptr got=%0d exp=0", hb_wr_ptr); end
      checks++;
      if (hb_trig_ptr !== 3'd5) begin failures++; $display("FAIL trig_ptr_hold got=%0d exp=5", hb_trig_ptr); end
      checks++;
      if (stb_cnt != 4) begin failures++; $display("FAIL trig_stb_count got=%0d exp=4", stb_cnt); end
   endtask

   task automatic test_frozen;
      stb_cnt = 0;
      for (int i = 0; i < 4; i++) drive(1'b1, DW'(8'hD0 + i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (stb_cnt != 0) begin failures++; $display("FAIL frz_stb got=%0d exp=0", stb_cnt); end
      checks++;
      if (hb_state !== 2'd2 || hb_wr_ptr !== 3'd0) begin
         failures++; $display("FAIL frz_hold got st=%0d wr=%0d exp st=2 wr=0", hb_state, hb_wr_ptr);
      end
      drive(1'b1, DW'(8'hEE), 1'b0, 1'b1, 1'b0);
      checks++;
      if (su_agg_cnt_stb !== 1'b0) begin failures++; $display("FAIL clr_stb got=%0b exp=0", su_agg_cnt_stb); end
      checks++;
      if ({hb_state, hb_wr_ptr, hb_trig_ptr, hb_wrapped} !== '0) begin
         failures++;
         $display("FAIL clr_status got st=%0d wr=%0d trig=%0d wrap=%0b exp all 0",
                  hb_state, hb_wr_ptr, hb_trig_ptr, hb_wrapped);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (su_hb[i] !== exp_hb[i]) begin
            failures++; $display("FAIL frz_entry_%0d got=%0h exp=%0h", i, su_hb[i], exp_hb[i]);
         end
      end
   endtask

   task automatic test_freeze_and_zero_post;
      stb_cnt = 0;
      cfg_post_trig = 8'd3;
      drive(1'b1, DW'(8'hF0), 1'b0, 1'b0, 1'b1);
      drive(1'b1, DW'(8'hF1), 1'b1, 1'b0, 1'b1);
      drive(1'b1, DW'(8'hF2), 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (stb_cnt != 0) begin failures++; $display("FAIL hf_stb got=%0d exp=0", stb_cnt); end
      checks++;
      if (hb_state !== 2'd0 || hb_wr_ptr !== 3'd0) begin
         failures++; $display("FAIL hf_state got st=%0d wr=%0d exp st=0 wr=0", hb_state, hb_wr_ptr);
      end
      checks++;
      if (su_hb[0] !== exp_hb[0]) begin failures++; $display("FAIL hf_entry0 got=%0h exp=%0h", su_hb[0], exp_hb[0]); end
      cfg_post_trig = 8'd0;
      drive(1'b1, DW'(8'h55), 1'b1, 1'b0, 1'b0);
      checks++;
      if (hb_state !== 2'd2 || hb_trig_ptr !== 3'd1 || hb_wr_ptr !== 3'd1) begin
         failures++;
         $display("FAIL zero_post got st=%0d trig=%0d wr=%0d exp st=2 trig=1 wr=1", hb_state, hb_trig_ptr, hb_wr_ptr);
      end
      checks++;
      if (su_hb[0] !== DW'(8'h55)) begin failures++; $display("FAIL zero_post_entry got=%0h exp=55", su_hb[0]); end
      drive(1'b1, DW'(8'h66), 1'b1, 1'b1, 1'b0);
      checks++;
      if (hb_state !== 2'd0 || hb_wr_ptr !== 3'd0 || su_agg_cnt_stb !== 1'b0) begin
         failures++;
         $display("FAIL clr_prio got st=%0d wr=%0d stb=%0b exp st=0 wr=0 stb=0", hb_state, hb_wr_ptr, su_agg_cnt_stb);
      end
   endtask

   task automatic test_async_reset;
      cfg_post_trig = 8'd5;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, DW'(8'h71), 1'b0, 1'b0, 1'b0);
      drive(1'b1, DW'(8'h72), 1'b0, 1'b0, 1'b0);
      checks++;
      if (hb_state !== 2'd1 || su_agg_cnt_stb !== 1'b1) begin
         failures++; $display("FAIL ar_pre got st=%0d stb=%0b exp st=1 stb=1", hb_state, su_agg_cnt_stb);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (su_hb !== '0) begin failures++; $display("FAIL ar_su_hb got=%0h exp=0", su_hb); end
      checks++;
      if ({hb_wr_ptr, hb_trig_ptr, hb_wrapped, hb_state, su_agg_cnt_stb} !== '0) begin
         failures++;
         $display("FAIL ar_status got wr=%0d trig=%0d wrap=%0b st=%0d stb=%0b exp all 0",
                  hb_wr_ptr, hb_trig_ptr, hb_wrapped, hb_state, su_agg_cnt_stb);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_capture();
      test_wrap();
      test_trigger();
      test_frozen();
      test_freeze_and_zero_post();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cr_su_hb_capture.md
Name: cr_su_hb_capture

Overview:
- Upstream producer for the SU register file.
- Captures 108-bit SU status words into an 8-entry circular history buffer and exposes all entries in parallel as su_hb[7:0] for software readback.
- Provides a trigger/post-trigger freeze mechanism, buffer status fields for hb_sup, and a one-cycle su_agg_cnt_stb per captured word that drives the aggregate SU event counter.

Parameters:
N_ENTRIES, 8, history depth; power of two; pointer width is log2(N_ENTRIES)
DATA_W, 108, captured word width
CNT_W, 8, width of cfg_post_trig and the post-trigger down-counter

Ports:
clk  input  1  core clock
rst_n  input  1  reset; asynchronous, active-low
in_vld  input  1  capture request; in_data is valid this cycle
in_data  input  DATA_W  status word to capture
trig  input  1  single-cycle trigger pulse
hb_clear  input  1  single-cycle re-arm pulse from debug config
hb_freeze  input  1  level; suppresses capture while high
cfg_post_trig  input  CNT_W  number of captures taken after trigger before freezing
su_hb  output  [N_ENTRIES-1:0][DATA_W-1:0]  buffer contents; entry i is stored word i
hb_wr_ptr  output  3  next entry to be written
hb_trig_ptr  output  3  value of hb_wr_ptr when the trigger was accepted
hb_wrapped  output  1  buffer has wrapped at least once since the last clear/reset
hb_state  output  2  0 = RUN, 1 = POST, 2 = FROZEN
su_agg_cnt_stb  output  1  pulse, one per accepted capture

Behaviour:
- Reset: all su_hb entries 0; hb_wr_ptr 0; hb_trig_ptr 0; hb_wrapped 0; hb_state RUN; post counter 0; su_agg_cnt_stb 0. Reset asserted mid-operation returns every output to these values immediately (asynchronous).

Accept rule:
- acc = in_vld & ~hb_freeze & (state != FROZEN) & ~hb_clear.
- On acc: su_hb[wr_ptr] <= in_data and wr_ptr <= wr_ptr+1 (mod 8), both visible the next cycle.
- On the 7->0 wrap, hb_wrapped <= 1 (sticky).
- su_agg_cnt_stb <= acc (registered; exactly 1-cycle latency; never asserted in FROZEN or while frozen by hb_freeze).

State machine:
- RUN:
  - trig & ~hb_freeze: hb_trig_ptr <= the pointer after any same-cycle capture (i.e. a same-cycle in_vld is captured first).
  - If cfg_post_trig == 0, go to FROZEN; otherwise go to POST with counter <= cfg_post_trig.
- POST:
  - Each acc decrements the counter.
  - An acc taken while counter == 1 moves to FROZEN at the next edge; that word is stored.
  - trig in POST is ignored. cfg_post_trig is sampled only on trigger entry.
- FROZEN: no writes and no pointer motion; trig is ignored. Only hb_clear exits.
- Any state with hb_clear: next state RUN, wr_ptr 0, hb_wrapped 0, hb_trig_ptr 0, counter 0.
  - Entries are retained, not zeroed.
  - hb_clear takes priority over trig and in_vld in the same cycle; the word is dropped and no strobe is issued.
- hb_freeze high: captures blocked and the counter holds. trig is ignored while hb_freeze is high, not queued.

Widths:
- Pointer arithmetic is 3-bit modulo.
- Counter is an unsigned CNT_W down-counter and never underflows.

Test Plan:
- Reset, then 5 in_vld words 0x1..0x5 -> su_hb[0..4] = 1..5, hb_wr_ptr = 5, hb_wrapped = 0, 5 strobes each 1 cycle after its in_vld.
- 10 consecutive captures 0xA0..0xA9 -> su_hb[0] = 0xA8, su_hb[1] = 0xA9, su_hb[2] = 0xA2, hb_wr_ptr = 2, hb_wrapped = 1.
- cfg_post_trig = 3; trig at wr_ptr = 4 with same-cycle in_vld, then 6 more in_vld -> hb_trig_ptr = 5, exactly 3 more words stored (entries 5, 6, 7), hb_state = FROZEN, wr_ptr = 0, 4 strobes total from trigger onward.
- FROZEN, then in_vld + trig for 4 cycles -> no entry change, no strobe; hb_clear with simultaneous in_vld -> hb_state RUN, wr_ptr 0, word dropped, entries unchanged.
- hb_freeze high for 3 in_vld cycles plus a trig -> no capture, no strobe, state stays RUN.
- rst_n dropped mid-POST -> all outputs return to reset values without waiting for a clock edge.
